// File: rtl/output_port_if.sv
// Link-side bundle of output_port: crossbar flit in, link flit out, credit return and VA grant.
// Flit layout: {type[1:0], vc_id[VC_SIZE-1:0], payload[DATA_W-1:0]}; type 0=HEAD 1=BODY 2=TAIL 3=HEADTAIL.
interface output_port_if #(
  parameter int unsigned VC_NUM = 2,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned FLIT_W  = 2 + VC_SIZE + DATA_W;

  logic [FLIT_W-1:0]  flit_i;
  logic               valid_flit_i;
  logic [FLIT_W-1:0]  data_o;
  logic               valid_flit_o;
  logic               credit_valid_i;
  logic [VC_SIZE-1:0] credit_vc_i;
  logic               vc_alloc_valid_i;
  logic [VC_SIZE-1:0] vc_alloc_id_i;
  logic [VC_NUM-1:0]  has_credit_o;
  logic [VC_NUM-1:0]  is_allocatable_o;
  logic               error_o;

  modport master (
    output flit_i, valid_flit_i, credit_valid_i, credit_vc_i, vc_alloc_valid_i, vc_alloc_id_i,
    input  data_o, valid_flit_o, has_credit_o, is_allocatable_o, error_o
  );

  modport slave (
    input  flit_i, valid_flit_i, credit_valid_i, credit_vc_i, vc_alloc_valid_i, vc_alloc_id_i,
    output data_o, valid_flit_o, has_credit_o, is_allocatable_o, error_o
  );
endinterface

// File: rtl/output_port.sv
// Router output port: registers granted flits onto the link, tracks per-VC downstream credits
// and per-VC allocation state, and flags credit-protocol violations.
module output_port #(
  parameter int unsigned BUFFER_SIZE = 8,
  parameter int unsigned VC_NUM      = 2,
  parameter int unsigned DATA_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  output_port_if.slave  bus
);
  localparam int unsigned VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned FLIT_W  = 2 + VC_SIZE + DATA_W;
  localparam int unsigned CNT_W   = $clog2(BUFFER_SIZE + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_SIZE);

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_type_e;
  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_CREDITS} vc_state_e;

  logic [CNT_W-1:0]  credit_q [VC_NUM];
  logic [CNT_W-1:0]  credit_d [VC_NUM];
  vc_state_e         state_q  [VC_NUM];
  vc_state_e         state_d  [VC_NUM];
  logic [FLIT_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;

  logic [VC_SIZE-1:0] send_vc;
  flit_type_e         send_type;
  logic               send_ok, send_tail, credit_ok;

  always_comb begin
    send_vc   = bus.flit_i[DATA_W +: VC_SIZE];
    send_type = flit_type_e'(bus.flit_i[FLIT_W-1 -: 2]);
    send_tail = (send_type == TAIL) || (send_type == HEADTAIL);
    send_ok   = bus.valid_flit_i && (credit_q[send_vc] != '0);
    credit_ok = bus.credit_valid_i && (credit_q[bus.credit_vc_i] != FULL);

    data_d  = data_q;
    valid_d = 1'b0;
    if (send_ok) begin
      data_d  = bus.flit_i;
      valid_d = 1'b1;
    end

    error_d = error_q
            | (bus.valid_flit_i && !send_ok)
            | (send_ok && state_q[send_vc] != ACTIVE)
            | (bus.credit_valid_i && !credit_ok)
            | (bus.vc_alloc_valid_i && state_q[bus.vc_alloc_id_i] != IDLE);

    for (int unsigned v = 0; v < VC_NUM; v++) begin
      credit_d[v] = credit_q[v];
      state_d[v]  = state_q[v];
      // A send and an accepted credit on the same VC cancel out.
      if (send_ok && send_vc == VC_SIZE'(v) && !(credit_ok && bus.credit_vc_i == VC_SIZE'(v)))
        credit_d[v] = credit_q[v] - CNT_W'(1);
      else if (credit_ok && bus.credit_vc_i == VC_SIZE'(v) && !(send_ok && send_vc == VC_SIZE'(v)))
        credit_d[v] = credit_q[v] + CNT_W'(1);

      unique case (state_q[v])
        IDLE:
          if (bus.vc_alloc_valid_i && bus.vc_alloc_id_i == VC_SIZE'(v)) state_d[v] = ACTIVE;
        ACTIVE:
          if (send_ok && send_vc == VC_SIZE'(v) && send_tail) state_d[v] = WAIT_CREDITS;
        WAIT_CREDITS:
          if (credit_q[v] == FULL) state_d[v] = IDLE;
        default:
          state_d[v] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        credit_q[v] <= FULL;
        state_q[v]  <= IDLE;
      end
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        credit_q[v] <= credit_d[v];
        state_q[v]  <= state_d[v];
      end
      data_q  <= data_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    bus.has_credit_o     = '0;
    bus.is_allocatable_o = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      bus.has_credit_o[v]     = (credit_q[v] != '0);
      bus.is_allocatable_o[v] = (state_q[v] == IDLE);
    end
  end

  assign bus.data_o       = data_q;
  assign bus.valid_flit_o = valid_q;
  assign bus.error_o      = error_q;
endmodule

// File: tb/tb_output_port.sv
// Directed bench for output_port (BUFFER_SIZE=8, VC_NUM=2): stimulus pushes expected link flits,
// a negedge monitor pops and compares them; status outputs are checked against constants.
module tb_output_port;
  localparam int unsigned DATA_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  output_port_if #(.VC_NUM(2), .DATA_W(DATA_W)) bus ();
  output_port #(.BUFFER_SIZE(8), .VC_NUM(2), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [18:0] exp_q [$];

  function automatic logic [18:0] mkflit(input logic [1:0] t, input logic vc, input logic [15:0] d);
    return {t, vc, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every link flit must match the oldest expected one.
  always @(negedge clk) begin
    if (rst && bus.valid_flit_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL link_unexpected: got %0h expected no flit at %0t", bus.data_o, $time);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if (bus.data_o !== e) begin
          failures++;
          $display("FAIL link_data: got %0h expected %0h at %0t", bus.data_o, e, $time);
        end
      end
    end
  end

  task automatic drive_idle();
    bus.flit_i = '0; bus.valid_flit_i = 1'b0;
    bus.credit_valid_i = 1'b0; bus.credit_vc_i = '0;
    bus.vc_alloc_valid_i = 1'b0; bus.vc_alloc_id_i = '0;
  endtask

  // One clock of stimulus; fwd=1 pushes the flit as an expected link output.
  task automatic step(input logic sv, input logic [1:0] st, input logic svc, input logic [15:0] d,
                      input logic cv, input logic cvc, input logic av, input logic avc, input logic fwd);
    bus.flit_i = mkflit(st, svc, d); bus.valid_flit_i = sv;
    bus.credit_valid_i = cv; bus.credit_vc_i = cvc;
    bus.vc_alloc_valid_i = av; bus.vc_alloc_id_i = avc;
    if (sv && fwd) exp_q.push_back(mkflit(st, svc, d));
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic send(input logic vc, input logic [1:0] t, input logic [15:0] d, input logic fwd);
    step(1'b1, t, vc, d, 1'b0, 1'b0, 1'b0, 1'b0, fwd);
  endtask
  task automatic alloc(input logic vc);
    step(1'b0, 2'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, vc, 1'b0);
  endtask
  task automatic credit(input logic vc);
    step(1'b0, 2'd0, 1'b0, 16'h0, 1'b1, vc, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic idle();
    step(1'b0, 2'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    drive_idle();
    do_reset();

    // 1: reset state
    idle();
    chk("rst_has_credit", 32'(bus.has_credit_o), 32'h3);
    chk("rst_alloc", 32'(bus.is_allocatable_o), 32'h3);
    chk("rst_valid", 32'(bus.valid_flit_o), 32'h0);
    chk("rst_error", 32'(bus.error_o), 32'h0);

    // 2: packet on VC1
    alloc(1'b1);
    chk("t2_alloc_after_va", 32'(bus.is_allocatable_o), 32'h1);
    send(1'b1, 2'd0, 16'h1101, 1'b1);
    send(1'b1, 2'd1, 16'h1102, 1'b1);
    send(1'b1, 2'd2, 16'h1103, 1'b1);
    chk("t2_alloc_wait", 32'(bus.is_allocatable_o), 32'h1);
    chk("t2_has_credit", 32'(bus.has_credit_o), 32'h3);

    // 3: return exactly 3 credits; VC1 frees one cycle after counter reaches 8
    credit(1'b1);
    credit(1'b1);
    chk("t3_alloc_7", 32'(bus.is_allocatable_o), 32'h1);
    credit(1'b1);
    chk("t3_alloc_8", 32'(bus.is_allocatable_o), 32'h1);
    idle();
    chk("t3_alloc_idle", 32'(bus.is_allocatable_o), 32'h3);
    chk("t3_error", 32'(bus.error_o), 32'h0);

    // 4: exhaust VC0 credits, then one flit too many
    alloc(1'b0);
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 2'd1, 16'h4000 + 16'(i), 1'b1);
      if (i == 6) chk("t4_has_credit_7", 32'(bus.has_credit_o), 32'h3);
    end
    chk("t4_has_credit_8", 32'(bus.has_credit_o), 32'h2);
    chk("t4_error_before", 32'(bus.error_o), 32'h0);
    send(1'b0, 2'd1, 16'h4008, 1'b0);
    chk("t4_drop_valid", 32'(bus.valid_flit_o), 32'h0);
    chk("t4_drop_error", 32'(bus.error_o), 32'h1);

    // 5: simultaneous send and credit on VC0 at credit 3
    do_reset();
    idle();
    chk("t5_error_cleared", 32'(bus.error_o), 32'h0);
    alloc(1'b0);
    for (int i = 0; i < 5; i++) send(1'b0, 2'd1, 16'h5000 + 16'(i), 1'b1);
    step(1'b1, 2'd1, 1'b0, 16'h5005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_same_cycle_error", 32'(bus.error_o), 32'h0);
    send(1'b0, 2'd1, 16'h5006, 1'b1);
    send(1'b0, 2'd1, 16'h5007, 1'b1);
    chk("t5_has_credit_1", 32'(bus.has_credit_o), 32'h3);
    send(1'b0, 2'd1, 16'h5008, 1'b1);
    chk("t5_has_credit_0", 32'(bus.has_credit_o), 32'h2);
    chk("t5_error_none", 32'(bus.error_o), 32'h0);
    credit(1'b1);
    chk("t5_overflow_error", 32'(bus.error_o), 32'h1);

    // 6: asynchronous reset mid-packet on VC1 at credit 2
    do_reset();
    idle();
    alloc(1'b1);
    for (int i = 0; i < 5; i++) send(1'b1, 2'd1, 16'h6000 + 16'(i), 1'b1);
    send(1'b1, 2'd1, 16'h6005, 1'b0);
    chk("t6_valid_before_rst", 32'(bus.valid_flit_o), 32'h1);
    rst = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bus.valid_flit_o), 32'h0);
    chk("t6_async_data", 32'(bus.data_o), 32'h0);
    chk("t6_async_has_credit", 32'(bus.has_credit_o), 32'h3);
    chk("t6_async_alloc", 32'(bus.is_allocatable_o), 32'h3);
    @(posedge clk); #1 rst = 1'b1;
    idle();
    alloc(1'b1);
    for (int i = 0; i < 8; i++) send(1'b1, 2'd1, 16'h6100 + 16'(i), 1'b1);
    chk("t6_full_refill", 32'(bus.has_credit_o), 32'h1);
    chk("t6_error", 32'(bus.error_o), 32'h0);
    idle();
    idle();
    chk("pending_flits", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
